minion_sprite_fetch: RTL and testbench
======================================

# minion_sprite_fetch

Per-pixel sprite fetch stage for one minion. It sits directly upstream of the minion sprite ROM (48×38 pixels, 4 animation frames, 7296 × 3-bit entries). It turns the VGA scan position and the minion's on-screen position into a ROM read address, then registers the returned colour index. It emits a 2-cycle-latency colour index plus a hit flag to the colour mapper, and owns the minion's walk-cycle animation counter.

## Interface

Parameters:
- SPR_W, 48, sprite width in pixels
- SPR_H, 38, sprite height in pixels
- NUM_FRAMES, 4, animation frames stored back-to-back in ROM
- ANIM_DIV, 8, video frames per animation step (≥1)
- TRANSPARENT, 3'd0, colour index treated as see-through

Ports:
- Clk  in  1  pixel clock
- Reset_n  in  1  reset; one clock, reset is asynchronous and active-low
- frame_start  in  1  one-cycle pulse at start of vertical blank
- pixel_valid  in  1  DrawX/DrawY is a visible pixel this cycle
- DrawX  in  10  current scan column, 0..639
- DrawY  in  10  current scan row, 0..479
- minion_x  in  10  sprite top-left column, may change any time
- minion_y  in  10  sprite top-left row
- minion_alive  in  1  draw enable for this minion
- read_address  out  19  to sprite ROM, combinational ROM read
- rom_data  in  3  colour index returned by ROM (same cycle as read_address)
- pixel_idx  out  3  colour index to colour mapper
- pixel_hit  out  1  minion pixel is opaque and should be drawn
- out_valid  out  1  pixel_idx/pixel_hit correspond to a pixel_valid input 2 cycles earlier

## Operation

- Shadow registers: on frame_start, latch minion_x, minion_y and minion_alive into pos_x, pos_y and alive_q. The rest of the frame uses only the shadow copies, so mid-frame position updates never tear.
- Animation:
  - div_cnt counts frame_start pulses 0..ANIM_DIV-1.
  - On the pulse where div_cnt = ANIM_DIV-1, div_cnt returns to 0 and anim_frame increments.
  - anim_frame wraps NUM_FRAMES-1 → 0.
  - The new anim_frame applies from the cycle after the pulse.
- Hit test, stage 1:
  - dx = DrawX − pos_x and dy = DrawY − pos_y, computed at 11-bit signed width.
  - in_box = alive_q & pixel_valid & 0 ≤ dx < SPR_W & 0 ≤ dy < SPR_H.
- Address, stage 1 register: read_address = anim_frame·SPR_W·SPR_H + dy·SPR_W + dx, zero-extended to 19 bits.
  - When in_box = 0, read_address = 0.
  - in_box and valid are carried alongside.
- Output, stage 2 register:
  - pixel_idx = rom_data when in_box, else TRANSPARENT.
  - pixel_hit = in_box & (rom_data ≠ TRANSPARENT).
  - out_valid = delayed pixel_valid.
- A sprite extending beyond column 639 or row 479 is clipped naturally, because only visible pixels are presented.

## Timing

- Reset values:
  - read_address = 0, pixel_idx = TRANSPARENT, pixel_hit = 0, out_valid = 0.
  - anim_frame = 0, div_cnt = 0, pos_x = pos_y = 0, alive_q = 0.
  - Nothing is drawn until the first frame_start after reset.
- Latency: exactly 2 cycles from DrawX/DrawY/pixel_valid to pixel_idx/pixel_hit/out_valid. Fully pipelined, one pixel per cycle, no stalls.
- frame_start coincident with pixel_valid: that pixel uses the old shadow values and old anim_frame.
- Reset_n asserted mid-line: all pipeline registers clear immediately. Outputs stay invalid until pixel_valid resumes, plus 2 cycles.
- Address upper bound: NUM_FRAMES·SPR_W·SPR_H − 1 = 7295. No wider address is ever produced.

## Structure

- Package minion_pkg holds:
  - SPR_W, SPR_H, NUM_FRAMES, FRAME_WORDS (= SPR_W·SPR_H = 1824)
  - ROM_AW = 19
  - the colour-index typedef (logic [2:0])
- Sub-module minion_anim_ctr contains div_cnt and anim_frame (inputs: Clk, Reset_n, frame_start; output: anim_frame).
- The hit test and the address pipeline live in the top level.

## Test plan

- Reset, then frame_start with minion (100,50) alive, NUM_FRAMES unchanged; pixel (110,60) → read_address 490 one cycle later; out_valid=1 and pixel_hit = (rom_data≠0) after 2 cycles.
- Pixels (99,50), (148,50), (100,88) with the same position → pixel_hit=0, pixel_idx=0, read_address=0; pixel (147,87) → address 1823.
- Clock 8 frame_start pulses → anim_frame=1; pixel (110,60) → address 2314. After 32 pulses → anim_frame wraps to 0. Frame 3, pixel offset (47,37) → address 7295.
- Change minion_x from 100 to 200 mid-frame → hits stay at column 100 until the next frame_start, then move to 200. A frame_start coincident with a pixel uses the old position.
- minion_alive=0 latched → no hit anywhere on the frame, even with the ROM returning 3'd5.
- Assert Reset_n low mid-line with the pipeline full → all outputs 0 on the same edge. anim_frame=0 after release. No hits before the next frame_start.

Source files
------------

// File: rtl/minion_pkg.sv
`default_nettype none
// ============================================================================
// Module      : minion_pkg
// Description : Shared sprite geometry, ROM address width and colour-index type
// Revision    : 1.0 - initial release
// ============================================================================
package minion_pkg;

    localparam int SPR_W       = 48;
    localparam int SPR_H       = 38;
    localparam int NUM_FRAMES  = 4;
    localparam int FRAME_WORDS = SPR_W * SPR_H;
    localparam int ROM_AW      = 19;

    typedef logic [2:0] color_idx_t;

endpackage : minion_pkg
`default_nettype wire

// File: rtl/minion_sprite_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : minion_sprite_fetch_if
// Description : Scan-position, sprite-ROM and colour-mapper signals of the fetch
// Revision    : 1.0 - initial release
// ============================================================================
interface minion_sprite_fetch_if;
    import minion_pkg::*;

    logic              frame_start;
    logic              pixel_valid;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic [9:0]        minion_x;
    logic [9:0]        minion_y;
    logic              minion_alive;
    logic [ROM_AW-1:0] read_address;
    color_idx_t        rom_data;
    color_idx_t        pixel_idx;
    logic              pixel_hit;
    logic              out_valid;

    // Master is the video/ROM side; slave is the fetch stage.
    modport master (
        output frame_start, pixel_valid, DrawX, DrawY,
        output minion_x, minion_y, minion_alive, rom_data,
        input  read_address, pixel_idx, pixel_hit, out_valid
    );

    modport slave (
        input  frame_start, pixel_valid, DrawX, DrawY,
        input  minion_x, minion_y, minion_alive, rom_data,
        output read_address, pixel_idx, pixel_hit, out_valid
    );

endinterface : minion_sprite_fetch_if
`default_nettype wire

// File: rtl/minion_anim_ctr.sv
`default_nettype none
// ============================================================================
// Module      : minion_anim_ctr
// Description : Walk-cycle animation counter, one step every ANIM_DIV frames
// Revision    : 1.0 - initial release
// ============================================================================
module minion_anim_ctr #(
    parameter  int NUM_FRAMES = 4,
    parameter  int ANIM_DIV   = 8,
    localparam int FRAME_BITS = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  frame_start,
    output logic [FRAME_BITS-1:0] anim_frame
);

    localparam int c_DIV_BITS = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [c_DIV_BITS-1:0] r_div_cnt;
    logic [FRAME_BITS-1:0] r_anim_frame;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_div_cnt    <= '0;
            r_anim_frame <= '0;
        end else if (frame_start) begin
            if (r_div_cnt == c_DIV_BITS'(ANIM_DIV - 1)) begin
                r_div_cnt <= '0;
                if (r_anim_frame == FRAME_BITS'(NUM_FRAMES - 1)) begin
                    r_anim_frame <= '0;
                end else begin
                    r_anim_frame <= r_anim_frame + 1'b1;
                end
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    assign anim_frame = r_anim_frame;

endmodule : minion_anim_ctr
`default_nettype wire

// File: rtl/minion_sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module      : minion_sprite_fetch
// Description : Two-stage hit test / sprite ROM address / colour-index pipeline
// Revision    : 1.0 - initial release
// ============================================================================
module minion_sprite_fetch
    import minion_pkg::color_idx_t;
    import minion_pkg::ROM_AW;
#(
    parameter int         SPR_W       = minion_pkg::SPR_W,
    parameter int         SPR_H       = minion_pkg::SPR_H,
    parameter int         NUM_FRAMES  = minion_pkg::NUM_FRAMES,
    parameter int         ANIM_DIV    = 8,
    parameter color_idx_t TRANSPARENT = 3'd0
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    minion_sprite_fetch_if.slave  bus
);

    localparam int c_FRAME_WORDS = SPR_W * SPR_H;
    localparam int c_FRAME_BITS  = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

    // Shadow copies of the sprite state, refreshed only at frame_start
    logic [9:0]              r_pos_x;
    logic [9:0]              r_pos_y;
    logic                    r_alive;

    logic [c_FRAME_BITS-1:0] w_anim_frame;

    logic signed [10:0]      w_dx;
    logic signed [10:0]      w_dy;
    logic                    w_dx_ok;
    logic                    w_dy_ok;
    logic                    w_in_box;
    logic [ROM_AW-1:0]       w_addr;

    logic [ROM_AW-1:0]       r_read_address;
    logic                    r_in_box;
    logic                    r_valid;

    color_idx_t              r_pixel_idx;
    logic                    r_pixel_hit;
    logic                    r_out_valid;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pos_x <= '0;
            r_pos_y <= '0;
            r_alive <= 1'b0;
        end else if (bus.frame_start) begin
            r_pos_x <= bus.minion_x;
            r_pos_y <= bus.minion_y;
            r_alive <= bus.minion_alive;
        end
    end

    minion_anim_ctr #(
        .NUM_FRAMES (NUM_FRAMES),
        .ANIM_DIV   (ANIM_DIV)
    ) u_anim_ctr (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (bus.frame_start),
        .anim_frame  (w_anim_frame)
    );

    // Offsets are signed so pixels left of / above the sprite come out negative
    assign w_dx = $signed({1'b0, bus.DrawX}) - $signed({1'b0, r_pos_x});
    assign w_dy = $signed({1'b0, bus.DrawY}) - $signed({1'b0, r_pos_y});

    assign w_dx_ok  = ~w_dx[10] & (w_dx[9:0] < 10'(SPR_W));
    assign w_dy_ok  = ~w_dy[10] & (w_dy[9:0] < 10'(SPR_H));
    assign w_in_box = r_alive & bus.pixel_valid & w_dx_ok & w_dy_ok;

    assign w_addr = ROM_AW'(w_anim_frame) * ROM_AW'(c_FRAME_WORDS)
                  + ROM_AW'(w_dy[9:0])    * ROM_AW'(SPR_W)
                  + ROM_AW'(w_dx[9:0]);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_read_address <= '0;
            r_in_box       <= 1'b0;
            r_valid        <= 1'b0;
        end else begin
            r_read_address <= w_in_box ? w_addr : '0;
            r_in_box       <= w_in_box;
            r_valid        <= bus.pixel_valid;
        end
    end

    // The ROM answers combinationally, so rom_data belongs to r_read_address
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pixel_idx <= TRANSPARENT;
            r_pixel_hit <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_pixel_idx <= r_in_box ? bus.rom_data : TRANSPARENT;
            r_pixel_hit <= r_in_box & (bus.rom_data != TRANSPARENT);
            r_out_valid <= r_valid;
        end
    end

    assign bus.read_address = r_read_address;
    assign bus.pixel_idx    = r_pixel_idx;
    assign bus.pixel_hit    = r_pixel_hit;
    assign bus.out_valid    = r_out_valid;

endmodule : minion_sprite_fetch
`default_nettype wire

// File: tb/tb_minion_sprite_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_minion_sprite_fetch
// Description : Scoreboard bench for the minion sprite fetch pipeline
// Revision    : 1.0 - initial release
// ============================================================================
module tb_minion_sprite_fetch;

    typedef struct {
        logic [18:0] addr;
        logic        in_box;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rom_force = 1'b0;
    logic pv_d1;

    int errors = 0;
    int checks = 0;

    exp_t addr_q[$];
    exp_t px_q[$];

    minion_sprite_fetch_if bus ();

    minion_sprite_fetch dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Sprite ROM stand-in: a fixed scramble of the address, or a forced 5
    function automatic logic [2:0] rom_fn(input logic [18:0] a);
        return a[2:0] ^ a[5:3];
    endfunction

    assign bus.rom_data = rom_force ? 3'd5 : rom_fn(bus.read_address);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pv_d1 <= 1'b0;
        else        pv_d1 <= bus.pixel_valid;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a stage-1 or stage-2 result
    always @(negedge clk) begin
        if (rst_n) begin
            if (pv_d1) begin
                if (addr_q.size() == 0) begin
                    chk("addr_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = addr_q.pop_front();
                    chk("read_address", int'(bus.read_address), int'(e.addr));
                end
            end
            if (bus.out_valid) begin
                if (px_q.size() == 0) begin
                    chk("out_valid_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    logic [2:0] exp_idx;
                    e = px_q.pop_front();
                    exp_idx = !e.in_box ? 3'd0 : (rom_force ? 3'd5 : rom_fn(e.addr));
                    chk("pixel_idx", int'(bus.pixel_idx), int'(exp_idx));
                    chk("pixel_hit", int'(bus.pixel_hit), int'(e.in_box && exp_idx != 3'd0));
                end
            end
        end
    end

    task automatic pix(input int x, input int y, input int addr, input bit inb, input bit fs);
        exp_t e;
        bus.DrawX       = 10'(x);
        bus.DrawY       = 10'(y);
        bus.pixel_valid = 1'b1;
        bus.frame_start = fs;
        e.addr   = 19'(addr);
        e.in_box = inb;
        addr_q.push_back(e);
        px_q.push_back(e);
        @(posedge clk); #1;
        bus.pixel_valid = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_start = 1'b1;
            @(posedge clk); #1;
            bus.frame_start = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic set_minion(input int x, input int y, input bit alive);
        bus.minion_x     = 10'(x);
        bus.minion_y     = 10'(y);
        bus.minion_alive = alive;
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.pixel_valid = 1'b0;
        bus.DrawX       = '0;
        bus.DrawY       = '0;
        set_minion(0, 0, 1'b1);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read_address", int'(bus.read_address), 0);
        chk("rst_pixel_idx", int'(bus.pixel_idx), 0);
        chk("rst_pixel_hit", int'(bus.pixel_hit), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        rst_n = 1'b1;
        idle(2);

        // No frame_start yet: shadow alive is still 0
        pix(10, 10, 0, 0, 0);
        idle(3);

        // Basic hit test and box edges at (100,50), frame 0
        set_minion(100, 50, 1'b1);
        pulse(1);
        pix(110, 60, 490, 1, 0);
        pix(99, 50, 0, 0, 0);
        pix(148, 50, 0, 0, 0);
        pix(100, 88, 0, 0, 0);
        pix(147, 87, 1823, 1, 0);
        pix(100, 50, 0, 1, 0);
        idle(3);

        // Mid-frame move is ignored until frame_start; coincident pixel sees old pos
        set_minion(200, 50, 1'b1);
        pix(110, 60, 490, 1, 0);
        pix(210, 60, 0, 0, 0);
        pix(110, 60, 490, 1, 1);
        pix(210, 60, 490, 1, 0);
        pix(110, 60, 0, 0, 0);
        idle(3);

        // Eight pulses in total -> anim_frame 1
        set_minion(100, 50, 1'b1);
        pulse(6);
        pix(110, 60, 2314, 1, 0);
        idle(3);

        // Twenty-four pulses -> frame 3, last address of the ROM
        pulse(16);
        pix(147, 87, 7295, 1, 0);
        idle(3);

        // Thirty-two pulses -> wraps back to frame 0
        pulse(8);
        pix(110, 60, 490, 1, 0);
        idle(3);

        // Dead minion: nothing drawn even though the ROM returns 5
        set_minion(100, 50, 1'b0);
        pulse(1);
        rom_force = 1'b1;
        pix(110, 60, 0, 0, 0);
        pix(147, 87, 0, 0, 0);
        idle(3);
        rom_force = 1'b0;

        // Forty pulses -> anim_frame 1, then reset with the pipeline full
        set_minion(100, 50, 1'b1);
        pulse(7);
        pix(110, 60, 2314, 1, 0);
        pix(111, 60, 2315, 1, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_read_address", int'(bus.read_address), 0);
        chk("midrst_pixel_idx", int'(bus.pixel_idx), 0);
        chk("midrst_pixel_hit", int'(bus.pixel_hit), 0);
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        addr_q.delete();
        px_q.delete();
        idle(2);
        rst_n = 1'b1;
        idle(2);
        chk("post_rst_out_valid", int'(bus.out_valid), 0);

        // Shadow state cleared: no hit until the next frame_start
        pix(110, 60, 0, 0, 0);
        idle(3);

        // Animation restarted from frame 0
        pulse(1);
        pix(110, 60, 490, 1, 0);
        idle(4);

        chk("queues_drained", addr_q.size() + px_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_minion_sprite_fetch
`default_nettype wire
